axi32_burst_host: RTL

Host-side burst sequencer and data buffer sitting directly upstream of the AXI3 32-bit bus controller (the `CTL*` handshake side). A 16-bit local host bus programs the address, burst length and direction, fills or drains a DEPTH x 32-bit beat buffer, and starts the transfer. The block then drives `CTLExec`/`CTLWrite`/`CTLWLast`, supplies write data and address/length to AXI, and captures read beats and bus-error status.

---
 rtl/axi32_burst_host.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/axi32_burst_host.sv
// Host-side burst sequencer for the AXI3 32-bit controller: host register file,
// DEPTH x 32-bit beat buffer, and a RUN/FINISH command FSM driving CTLExec/CTLWrite/CTLWLast.
module axi32_burst_host #(
    parameter int DEPTH = 8,
    parameter int PW    = 3
) (
    input  logic        AXIClock,
    input  logic        Reset,
    input  logic        HostWrite,
    input  logic        HostRead,
    input  logic [2:0]  HostAddr,
    input  logic [15:0] HostWData,
    output logic [15:0] HostRData,
    output logic [31:0] AXIARAddr,
    output logic [31:0] AXIAWAddr,
    output logic [3:0]  AXIARLen,
    output logic [3:0]  AXIAWLen,
    output logic [31:0] AXIWData,
    output logic [3:0]  AXIWStrb,
    input  logic [31:0] AXIRData,
    output logic        CTLExec,
    output logic        CTLWrite,
    output logic        CTLWLast,
    input  logic        CTLStart,
    input  logic        CTLEnd,
    input  logic        CTLReady,
    input  logic        CTLPutEn,
    input  logic        CTLGetEn,
    input  logic        CTLRBErr,
    input  logic        CTLWBErr
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   addr_lo_q, addr_hi_q;
    logic [PW-1:0] len_q, ptr_q, getptr_q, putptr_q;
    logic [PW:0]   putcnt_q;
    logic          write_q, done_q, rerr_q, werr_q;
    logic [15:0]   rdata_q;
    logic [31:0]   mem_q [DEPTH];

    logic          busy, host_wr_ok, start_req, put_ok, data_step;
    logic [15:0]   status, rd_mux;
    logic          unused_start;

    // Controller start pulse carries no information the sequencer needs.
    assign unused_start = CTLStart;

    assign busy       = (state_q != S_IDLE);
    assign host_wr_ok = HostWrite && !busy;
    assign start_req  = HostWrite && (HostAddr == 3'd3) && HostWData[0] && (state_q == S_IDLE);
    // Beats beyond LEN+1 are dropped so the buffer never sees surplus data.
    assign put_ok     = (state_q == S_RUN) && CTLPutEn && (putcnt_q <= (PW+1)'(len_q));
    assign data_step  = (host_wr_ok && ((HostAddr == 3'd5) || (HostAddr == 3'd6)))
                     || (HostRead   && ((HostAddr == 3'd5) || (HostAddr == 3'd6)));

    assign status = {8'h00, 4'(putcnt_q), werr_q, rerr_q, done_q, busy};

    always_ff @(posedge AXIClock or posedge Reset) begin
        if (Reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_req) state_d = S_RUN;
            S_RUN:    if (CTLReady)  state_d = S_FINISH;
            S_FINISH: if (CTLEnd)    state_d = S_IDLE;
            default:                 state_d = S_IDLE;
        endcase
    end

    always_comb begin
        CTLExec  = (state_q == S_RUN);
        CTLWrite = write_q;
        CTLWLast = (state_q == S_RUN) && write_q && (getptr_q == len_q);
    end

    always_comb begin
        rd_mux = 16'h0000;
        case (HostAddr)
            3'd0: rd_mux = addr_lo_q;
            3'd1: rd_mux = addr_hi_q;
            3'd2: rd_mux = 16'(len_q);
            3'd3: rd_mux = status;
            3'd4: rd_mux = 16'(ptr_q);
            3'd5: rd_mux = mem_q[ptr_q][15:0];
            3'd6: rd_mux = mem_q[ptr_q][31:16];
            default: rd_mux = 16'h0000;
        endcase
    end

    always_ff @(posedge AXIClock or posedge Reset) begin
        if (Reset) begin
            addr_lo_q <= '0;
            addr_hi_q <= '0;
            len_q     <= '0;
            ptr_q     <= '0;
            getptr_q  <= '0;
            putptr_q  <= '0;
            putcnt_q  <= '0;
            write_q   <= 1'b0;
            done_q    <= 1'b0;
            rerr_q    <= 1'b0;
            werr_q    <= 1'b0;
            rdata_q   <= '0;
        end else begin
            if (host_wr_ok) begin
                case (HostAddr)
                    3'd0: addr_lo_q <= HostWData;
                    3'd1: addr_hi_q <= HostWData;
                    3'd2: len_q <= (HostWData >= 16'(DEPTH)) ? PW'(DEPTH-1) : HostWData[PW-1:0];
                    default: ;
                endcase
            end
            if (HostWrite && (HostAddr == 3'd4)) ptr_q <= HostWData[PW-1:0];
            else if (data_step)                  ptr_q <= ptr_q + PW'(1);
            if (HostRead) rdata_q <= rd_mux;

            if (start_req) begin
                write_q  <= HostWData[1];
                done_q   <= 1'b0;
                rerr_q   <= 1'b0;
                werr_q   <= 1'b0;
                getptr_q <= '0;
                putptr_q <= '0;
                putcnt_q <= '0;
            end
            if (state_q == S_RUN) begin
                if (CTLGetEn && (getptr_q != PW'(DEPTH-1))) getptr_q <= getptr_q + PW'(1);
                if (put_ok) begin
                    putptr_q <= putptr_q + PW'(1);
                    putcnt_q <= putcnt_q + (PW+1)'(1);
                end
                if (CTLReady) begin
                    rerr_q <= rerr_q | CTLRBErr;
                    werr_q <= werr_q | CTLWBErr;
                end
            end
            if ((state_q == S_FINISH) && CTLEnd) begin
                done_q  <= 1'b1;
                write_q <= 1'b0;
            end
        end
    end

    // Host fills only while idle and the controller only while running, so the ports never collide.
    always_ff @(posedge AXIClock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (put_ok) mem_q[putptr_q] <= AXIRData;
            if (host_wr_ok && (HostAddr == 3'd5)) mem_q[ptr_q][15:0]  <= HostWData;
            if (host_wr_ok && (HostAddr == 3'd6)) mem_q[ptr_q][31:16] <= HostWData;
        end
    end

    assign HostRData = rdata_q;
    assign AXIARAddr = {addr_hi_q, addr_lo_q[15:2], 2'b00};
    assign AXIAWAddr = {addr_hi_q, addr_lo_q[15:2], 2'b00};
    assign AXIARLen  = 4'(len_q);
    assign AXIAWLen  = 4'(len_q);
    assign AXIWData  = mem_q[getptr_q];
    assign AXIWStrb  = 4'hF;

endmodule
